ae_exposure_ctrl: RTL

AE_EXPOSURE_CTRL -- requirements
Module: ae_exposure_ctrl

---
 rtl/ae_exposure_ctrl.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/ae_exposure_ctrl.sv
// Auto-exposure controller: accumulates frame luma, divides for the mean,
// steps the exposure toward a target band and writes it over a req/ack port.
module ae_exposure_ctrl #(
  parameter int          IMG_HDISP   = 1280,
  parameter int          IMG_VDISP   = 720,
  parameter logic [7:0]  TARGET      = 8'd110,
  parameter logic [7:0]  HYST        = 8'd8,
  parameter logic [15:0] EXP_INIT    = 16'd256,
  parameter logic [15:0] EXP_MIN     = 16'd16,
  parameter logic [15:0] EXP_MAX     = 16'd1000,
  parameter int          STEP_SHIFT  = 3,
  parameter int          SKIP_FRAMES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic [7:0]  per_img_red,
  input  logic [7:0]  per_img_green,
  input  logic [7:0]  per_img_blue,
  input  logic [1:0]  mirror_in,
  input  logic        cfg_ack,
  output logic        cfg_req,
  output logic [15:0] cfg_data,
  output logic [15:0] exp_value,
  output logic [7:0]  avg_luma,
  output logic        ae_locked,
  output logic [1:0]  mirror_out
);

  localparam logic [8:0] SKIP_N    = 9'(SKIP_FRAMES);
  localparam logic [8:0] DARK_TH   = {1'b0, TARGET} - {1'b0, HYST};
  localparam logic [8:0] BRIGHT_TH = {1'b0, TARGET} + {1'b0, HYST};

  // The pixel counter is 20 bits wide; a larger frame would wrap it.
  if (IMG_HDISP * IMG_VDISP > 32'h000F_FFFF) begin : g_frame_too_big
    $error("ae_exposure_ctrl: frame size exceeds 20-bit pixel count");
  end

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DIVIDE,
    DECIDE,
    WRITE,
    SKIP
  } state_t;

  state_t state, state_nxt;

  logic        vsync_d;
  logic        frame_end;
  logic [9:0]  luma;
  logic [27:0] acc_sum;
  logic [19:0] acc_cnt;
  logic [27:0] dvd;
  logic [19:0] dsr;
  logic [19:0] rem;
  logic [27:0] quo;
  logic [4:0]  div_cnt;
  logic [8:0]  skip_cnt;

  logic [20:0] rem_sh;
  logic [21:0] rem_diff;
  logic        rem_ge;
  logic [19:0] rem_nxt;
  logic [27:0] quo_nxt;

  logic [15:0] step;
  logic [16:0] exp_up;
  logic [16:0] exp_dn;
  logic [15:0] new_exp;
  logic        is_dark;
  logic        is_bright;

  logic acc_clr, acc_latch, div_step, div_last;
  logic lock_ld, lock_val, wr_start, wr_commit, skip_inc;

  assign luma = ({2'b00, per_img_red} + {1'b0, per_img_green, 1'b0} + {2'b00, per_img_blue}) >> 2;

  // Restoring divider: one quotient bit per step.
  assign rem_sh   = {rem, dvd[27]};
  assign rem_diff = {1'b0, rem_sh} - {2'b00, dsr};
  assign rem_ge   = ~rem_diff[21];
  assign rem_nxt  = rem_ge ? rem_diff[19:0] : rem_sh[19:0];
  assign quo_nxt  = {quo[26:0], rem_ge};

  // Exposure step computation, clamped to the allowed range.
  always_comb begin
    step = exp_value >> STEP_SHIFT;
    if (step == '0) step = 16'd1;
    exp_up    = {1'b0, exp_value} + {1'b0, step};
    exp_dn    = {1'b0, exp_value} - {1'b0, step};
    is_dark   = {1'b0, avg_luma} < DARK_TH;
    is_bright = {1'b0, avg_luma} > BRIGHT_TH;
    if (is_dark) begin
      new_exp = (exp_up > {1'b0, EXP_MAX}) ? EXP_MAX : exp_up[15:0];
    end else begin
      new_exp = (exp_dn[16] || exp_dn[15:0] < EXP_MIN) ? EXP_MIN : exp_dn[15:0];
    end
  end

  // Registered frame-end detection and frame-synchronous mirror mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_d    <= 1'b0;
      frame_end  <= 1'b0;
      mirror_out <= 2'b00;
    end else begin
      vsync_d   <= per_frame_vsync;
      frame_end <= vsync_d & ~per_frame_vsync;
      if (frame_end) mirror_out <= mirror_in;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    acc_latch = 1'b0;
    div_step  = 1'b0;
    div_last  = 1'b0;
    lock_ld   = 1'b0;
    lock_val  = 1'b0;
    wr_start  = 1'b0;
    wr_commit = 1'b0;
    skip_inc  = 1'b0;
    // Frames ending while busy are discarded; restart accumulation.
    if (frame_end && (state == DIVIDE || state == DECIDE || state == WRITE)) acc_clr = 1'b1;
    unique case (state)
      IDLE: begin
        if (frame_end && enable) begin
          state_nxt = ACCUM;
          acc_clr   = 1'b1;
        end
      end
      ACCUM: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (frame_end) begin
          if (acc_cnt == '0) begin
            acc_clr = 1'b1;
          end else begin
            acc_latch = 1'b1;
            state_nxt = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else begin
          div_step = 1'b1;
          if (div_cnt == 5'd27) begin
            div_last  = 1'b1;
            state_nxt = DECIDE;
          end
        end
      end
      DECIDE: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else begin
          lock_ld = 1'b1;
          if (!is_dark && !is_bright) begin
            lock_val  = 1'b1;
            state_nxt = ACCUM;
          end else if (new_exp == exp_value) begin
            state_nxt = ACCUM;
          end else begin
            wr_start  = 1'b1;
            state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        if (cfg_ack) begin
          wr_commit = 1'b1;
          if (!enable) begin
            state_nxt = IDLE;
          end else if (SKIP_N == '0) begin
            state_nxt = ACCUM;
            acc_clr   = 1'b1;
          end else begin
            state_nxt = SKIP;
          end
        end
      end
      SKIP: begin
        if (!enable) begin
          state_nxt = IDLE;
        end else if (frame_end) begin
          if (skip_cnt + 9'd1 >= SKIP_N) begin
            state_nxt = ACCUM;
            acc_clr   = 1'b1;
          end else begin
            skip_inc = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Luma accumulators.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_sum <= '0;
      acc_cnt <= '0;
    end else if (acc_clr || acc_latch) begin
      acc_sum <= '0;
      acc_cnt <= '0;
    end else if (state == ACCUM && per_frame_href) begin
      acc_sum <= acc_sum + {18'd0, luma};
      acc_cnt <= acc_cnt + 20'd1;
    end
  end

  // Sequential divider and mean register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd      <= '0;
      dsr      <= '0;
      rem      <= '0;
      quo      <= '0;
      div_cnt  <= '0;
      avg_luma <= '0;
    end else if (acc_latch) begin
      dvd     <= acc_sum;
      dsr     <= acc_cnt;
      rem     <= '0;
      quo     <= '0;
      div_cnt <= '0;
    end else if (div_step) begin
      dvd     <= {dvd[26:0], 1'b0};
      rem     <= rem_nxt;
      quo     <= quo_nxt;
      div_cnt <= div_cnt + 5'd1;
      if (div_last) avg_luma <= (quo_nxt[27:8] != '0) ? 8'hFF : quo_nxt[7:0];
    end
  end

  // Lock flag, write handshake, committed exposure and skip counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ae_locked <= 1'b0;
      cfg_req   <= 1'b0;
      cfg_data  <= '0;
      exp_value <= EXP_INIT;
      skip_cnt  <= '0;
    end else begin
      if (lock_ld) ae_locked <= lock_val;
      if (wr_start) begin
        cfg_req  <= 1'b1;
        cfg_data <= new_exp;
      end else if (wr_commit) begin
        cfg_req   <= 1'b0;
        exp_value <= cfg_data;
      end
      if (wr_commit)     skip_cnt <= '0;
      else if (skip_inc) skip_cnt <= skip_cnt + 9'd1;
    end
  end

endmodule
